// File: rtl/pipe_pkg.sv
// Shared pipeline types for the core's elastic stages.
//   skid_state_e : occupancy state of a skid_buffer; the encoding equals the
//                  number of held entries, so it doubles as the count output.
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Occupancy of a skid buffer in a given state.
  function automatic logic [1:0] skid_count(input skid_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry elastic pipeline stage (skid buffer).
//
// Decouples a producer from a consumer that may stall. The main register
// drives out_data. The skid register catches the one payload that arrives
// while the consumer stalls. in_ready and out_valid are flops, so there is no
// combinational path from out_ready to in_ready.
//
// Handshake rules, both sides: a payload moves on a rising clk edge only when
// valid && ready are both high in the cycle before that edge. A valid payload
// stays valid and unchanged until it is taken. in_valid may drop without a
// transfer, and nothing is captured in that case.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous flush, discards held entries and wins over transfers
//   in_valid  : producer has a payload
//   in_ready  : buffer can accept (registered)
//   in_data   : producer payload
//   out_valid : buffer presents a payload (registered)
//   out_ready : consumer accepts
//   out_data  : head payload (registered)
//   count     : occupancy 0..2, equal to the state encoding
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Data registers keep stale contents. Only the state is cleared.
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d = SKID_BUSY;
            main_d  = in_data;
          end
        end
        SKID_BUSY: begin
          if (push && !pop) begin
            state_d = SKID_FULL;
            skid_d  = in_data;
          end else if (push && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so in_valid cannot push.
          if (pop) begin
            state_d = SKID_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end

    // The handshake flags are decoded from the next state and then
    // registered, so they never depend combinationally on out_ready.
    in_ready_d  = (state_d != SKID_FULL);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = skid_count(state_q);

endmodule
